omem_ctrl: RTL and testbench

- Owns the single-port output memory (OMEM) behind the 4x4 MAC array.
- Performs the clear sweep at job start and per-row writeback of tile results, either overwrite (first N-tile) or read-modify-write accumulate (second N-tile, ACC=1).
- Services host drain reads at lowest priority.
- Sits between the tile controller / MAC array and the OMEM SRAM macro.

---
 rtl/omem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_omem_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/omem_ctrl.sv
// Output-memory controller: clear sweep, overwrite / saturating accumulate writeback, host drain reads.
// Latency: overwrite writes in the accept cycle; accumulate writes back one cycle later; host read data one cycle after RD_GNT.
// Backpressure: WR_READY low during clear sweep and the accumulate write-back cycle; host reads only use otherwise idle port cycles.
module omem_ctrl #(
  parameter int OW    = 20,
  parameter int LANES = 4,
  parameter int AW    = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CLR_REQ,
  input  logic                WR_VALID,
  output logic                WR_READY,
  input  logic [AW-1:0]       WR_ADDR,
  input  logic [LANES*OW-1:0] WR_DATA,
  input  logic                ACC,
  input  logic                RD_REQ,
  input  logic [AW-1:0]       RD_ADDR,
  output logic                RD_GNT,
  output logic                RD_VALID,
  output logic [LANES*OW-1:0] RD_DATA,
  output logic                BUSY,
  output logic                OVF,
  output logic                MEM_CEN,
  output logic                MEM_WEN,
  output logic [AW-1:0]       MEM_ADDR,
  output logic [LANES*OW-1:0] MEM_WDATA,
  input  logic [LANES*OW-1:0] MEM_RDATA
);

  // RMW_WR is the single write-back cycle of an accumulate; its read was issued from IDLE.
  typedef enum logic [1:0] {IDLE, CLEAR, RMW_WR} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [AW-1:0]         acc_addr_q, acc_addr_d;
  logic [LANES*OW-1:0]   acc_data_q, acc_data_d;
  logic                  ovf_q, ovf_d;
  logic                  init_q, init_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [LANES*OW-1:0]   rd_hold_q, rd_hold_d;

  logic [LANES*OW-1:0]   sum_dat;
  logic                  sat_any;
  logic signed [OW-1:0]  lane_a, lane_b;
  logic [OW:0]           lane_sum;

  // Lane-wise signed add of stored row and incoming partial result, clamped to the OW-bit range.
  always_comb begin
    sum_dat  = '0;
    sat_any  = 1'b0;
    lane_a   = '0;
    lane_b   = '0;
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a   = MEM_RDATA[i*OW +: OW];
      lane_b   = acc_data_q[i*OW +: OW];
      lane_sum = {lane_a[OW-1], lane_a} + {lane_b[OW-1], lane_b};
      if (lane_sum[OW] != lane_sum[OW-1]) begin
        sat_any = 1'b1;
        sum_dat[i*OW +: OW] = lane_sum[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      end else begin
        sum_dat[i*OW +: OW] = lane_sum[OW-1:0];
      end
    end
  end

  // Port arbitration and next state: clear sweep > RMW write-back > new MAC write > host read.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    acc_addr_d = acc_addr_q;
    acc_data_d = acc_data_q;
    ovf_d      = ovf_q;
    init_d     = 1'b1;
    WR_READY   = 1'b0;
    RD_GNT     = 1'b0;
    MEM_CEN    = 1'b0;
    MEM_WEN    = 1'b0;
    MEM_ADDR   = '0;
    MEM_WDATA  = '0;
    case (state_q)
      IDLE: begin
        // init_q keeps the port quiet in the cycle right after reset.
        if (init_q) begin
          if (CLR_REQ) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
            ovf_d     = 1'b0;
          end else begin
            WR_READY = 1'b1;
            if (WR_VALID) begin
              MEM_CEN  = 1'b1;
              MEM_ADDR = WR_ADDR;
              if (ACC) begin
                acc_addr_d = WR_ADDR;
                acc_data_d = WR_DATA;
                state_d    = RMW_WR;
              end else begin
                MEM_WEN   = 1'b1;
                MEM_WDATA = WR_DATA;
              end
            end else if (RD_REQ) begin
              RD_GNT   = 1'b1;
              MEM_CEN  = 1'b1;
              MEM_ADDR = RD_ADDR;
            end
          end
        end
      end
      CLEAR: begin
        MEM_CEN   = 1'b1;
        MEM_WEN   = 1'b1;
        MEM_ADDR  = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == '1) state_d = IDLE;
      end
      RMW_WR: begin
        MEM_CEN   = 1'b1;
        MEM_WEN   = 1'b1;
        MEM_ADDR  = acc_addr_q;
        MEM_WDATA = sum_dat;
        if (sat_any) ovf_d = 1'b1;
        // A clear requested during the accumulate starts right after the write-back.
        if (CLR_REQ) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
          ovf_d     = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_vld_d  = RD_GNT;
    rd_hold_d = rd_vld_q ? MEM_RDATA : rd_hold_q;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      acc_addr_q <= '0;
      acc_data_q <= '0;
      ovf_q      <= 1'b0;
      init_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      acc_addr_q <= acc_addr_d;
      acc_data_q <= acc_data_d;
      ovf_q      <= ovf_d;
      init_q     <= init_d;
      rd_vld_q   <= rd_vld_d;
      rd_hold_q  <= rd_hold_d;
    end
  end

  assign RD_VALID = rd_vld_q;
  assign RD_DATA  = rd_vld_q ? MEM_RDATA : rd_hold_q;
  assign BUSY     = (state_q != IDLE);
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_omem_ctrl.sv
// Bench for omem_ctrl: behavioural SRAM, row/lane reference model, directed and random scenarios.
module tb_omem_ctrl;
  localparam int OW = 20;
  localparam int LANES = 4;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int MAXV = 524287;
  localparam int MINV = -524288;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_req = 1'b0;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [LANES*OW-1:0] wr_data = '0;
  logic acc = 1'b0;
  logic rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic rd_gnt, rd_valid, busy, ovf, mem_cen, mem_wen;
  logic [LANES*OW-1:0] rd_data, mem_wdata;
  logic [LANES*OW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  logic [LANES*OW-1:0] sram [DEPTH];

  int n_chk = 0;
  int n_pass = 0;
  int exp_mem [DEPTH][LANES];
  bit exp_ovf = 1'b0;

  always #5 clk = ~clk;

  omem_ctrl #(.OW(OW), .LANES(LANES), .AW(AW)) dut (
    .CLK(clk), .RST(rst), .CLR_REQ(clr_req),
    .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .ACC(acc),
    .RD_REQ(rd_req), .RD_ADDR(rd_addr), .RD_GNT(rd_gnt), .RD_VALID(rd_valid), .RD_DATA(rd_data),
    .BUSY(busy), .OVF(ovf),
    .MEM_CEN(mem_cen), .MEM_WEN(mem_wen), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata)
  );

  // Single-port SRAM: write-then-read ordering, read data one cycle after access.
  always @(posedge clk) begin
    if (mem_cen) begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      else         mem_rdata <= sram[mem_addr];
    end
  end

  function automatic logic [LANES*OW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    logic [LANES*OW-1:0] r;
    int v;
    for (int i = 0; i < LANES; i++) begin
      v = (i == 0) ? l0 : (i == 1) ? l1 : (i == 2) ? l2 : l3;
      r[i*OW +: OW] = v[OW-1:0];
    end
    return r;
  endfunction

  function automatic logic [LANES*OW-1:0] exp_row(input int a);
    logic [LANES*OW-1:0] r;
    int v;
    for (int i = 0; i < LANES; i++) begin
      v = exp_mem[a][i];
      r[i*OW +: OW] = v[OW-1:0];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int a = 0; a < DEPTH; a++)
      for (int i = 0; i < LANES; i++) exp_mem[a][i] = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic model_write(input int a, input logic [LANES*OW-1:0] d, input bit accm);
    logic signed [OW-1:0] t;
    int s;
    for (int i = 0; i < LANES; i++) begin
      t = d[i*OW +: OW];
      s = accm ? exp_mem[a][i] + int'(t) : int'(t);
      if (s > MAXV) begin s = MAXV; exp_ovf = 1'b1; end
      if (s < MINV) begin s = MINV; exp_ovf = 1'b1; end
      exp_mem[a][i] = s;
    end
  endtask

  // Present a write and hold it until accepted; returns at the negedge after acceptance.
  task automatic do_write(input logic [AW-1:0] a, input logic [LANES*OW-1:0] d, input bit accm);
    int n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; acc = accm;
    #1;
    while (!wr_ready && n < 20) begin @(negedge clk); #1; n++; end
    n_chk++;
    if (!wr_ready) $display("FAIL write_accept: wr_ready=%b after %0d cycles, required 1", wr_ready, n);
    else begin n_pass++; model_write(int'(a), d, accm); end
    @(negedge clk);
    wr_valid = 1'b0; acc = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [LANES*OW-1:0] d, output bit ok);
    int n = 0;
    rd_req = 1'b1; rd_addr = a;
    #1;
    while (!rd_gnt && n < 40) begin @(negedge clk); #1; n++; end
    if (!rd_gnt) begin
      rd_req = 1'b0; ok = 1'b0; d = '0;
      return;
    end
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    ok = rd_valid;
    d = rd_data;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    #1;
    while (busy && n < 40) begin @(negedge clk); #1; n++; end
    n_chk++;
    if (busy !== 1'b0) $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({wr_ready, rd_gnt, rd_valid, busy, ovf, mem_cen, mem_wen} !== 7'b0 || rd_data !== '0 ||
        mem_addr !== '0 || mem_wdata !== '0)
      $display("FAIL reset_outputs: rdy/gnt/vld/busy/ovf/cen/wen=%b rd_data=%h, required all 0",
               {wr_ready, rd_gnt, rd_valid, busy, ovf, mem_cen, mem_wen}, rd_data);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (wr_ready !== 1'b1) $display("FAIL reset_ready: wr_ready=%b, required 1", wr_ready);
    else n_pass++;
  endtask

  task automatic test_clear();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 4'd7;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_chk++;
      if (mem_cen !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== '0 ||
          busy !== 1'b1 || wr_ready !== 1'b0 || rd_gnt !== 1'b0)
        $display("FAIL clear_cycle%0d: cen=%b wen=%b addr=%0d wdata=%h busy=%b rdy=%b gnt=%b, required 1 1 %0d 0 1 0 0",
                 i, mem_cen, mem_wen, mem_addr, mem_wdata, busy, wr_ready, rd_gnt, i);
      else n_pass++;
      @(negedge clk);
    end
    #1;
    n_chk++;
    if (busy !== 1'b0 || rd_gnt !== 1'b1)
      $display("FAIL clear_end: busy=%b rd_gnt=%b, required 0 1", busy, rd_gnt);
    else n_pass++;
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    n_chk++;
    if (rd_valid !== 1'b1 || rd_data !== '0)
      $display("FAIL clear_read7: rd_valid=%b rd_data=%h, required 1 0", rd_valid, rd_data);
    else n_pass++;
    model_clear();
  endtask

  task automatic test_overwrite();
    logic [LANES*OW-1:0] d, last;
    bit ok;
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      d = pack4(r*4+1, r*4+2, r*4+3, r*4+4);
      wr_valid = 1'b1; wr_addr = AW'(r); wr_data = d; acc = 1'b0;
      #1;
      n_chk++;
      if (wr_ready !== 1'b1 || mem_cen !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== AW'(r) || mem_wdata !== d)
        $display("FAIL overwrite_cycle%0d: rdy=%b cen=%b wen=%b addr=%0d wdata=%h, required 1 1 1 %0d %h",
                 r, wr_ready, mem_cen, mem_wen, mem_addr, mem_wdata, r, d);
      else n_pass++;
      model_write(r, d, 1'b0);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    last = '0;
    for (int r = 0; r < 4; r++) begin
      host_read(AW'(r), d, ok);
      last = d;
      n_chk++;
      if (!ok || d !== exp_row(r))
        $display("FAIL overwrite_read%0d: valid=%b data=%h, required 1 %h", r, ok, d, exp_row(r));
      else n_pass++;
    end
    @(negedge clk); #1;
    n_chk++;
    if (rd_valid !== 1'b0 || rd_data !== last)
      $display("FAIL rd_data_hold: rd_valid=%b rd_data=%h, required 0 %h", rd_valid, rd_data, last);
    else n_pass++;
  endtask

  task automatic test_accumulate();
    logic [LANES*OW-1:0] d, q;
    logic [3:0] pat;
    bit ok;
    @(negedge clk);
    do_write(4'd2, '0, 1'b0);
    d = pack4(5, 5, 5, 5);
    wr_valid = 1'b1; wr_addr = 4'd2; wr_data = d; acc = 1'b1;
    #1; pat[3] = wr_ready;
    model_write(2, d, 1'b1);
    @(negedge clk); #1; pat[2] = wr_ready;
    n_chk++;
    if (mem_wen !== 1'b1 || mem_addr !== 4'd2 || mem_wdata !== pack4(5, 5, 5, 5))
      $display("FAIL acc_wb1: wen=%b addr=%0d wdata=%h, required 1 2 %h", mem_wen, mem_addr, mem_wdata, pack4(5, 5, 5, 5));
    else n_pass++;
    @(negedge clk); #1; pat[1] = wr_ready;
    model_write(2, d, 1'b1);
    @(negedge clk);
    wr_valid = 1'b0; acc = 1'b0;
    #1; pat[0] = wr_ready;
    n_chk++;
    if (pat !== 4'b1010) $display("FAIL acc_ready_pattern: got %b, required 1010", pat);
    else n_pass++;
    @(negedge clk);
    host_read(4'd2, q, ok);
    n_chk++;
    if (!ok || q !== pack4(10, 10, 10, 10) || q !== exp_row(2))
      $display("FAIL acc_read2: valid=%b data=%h, required 1 %h", ok, q, pack4(10, 10, 10, 10));
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [LANES*OW-1:0] q;
    bit ok;
    @(negedge clk);
    do_write(4'd5, pack4(MAXV, MINV, 100, -100), 1'b0);
    do_write(4'd5, pack4(1, -1, 7, -7), 1'b1);
    @(negedge clk); #1;
    n_chk++;
    if (ovf !== 1'b1 || exp_ovf !== 1'b1) $display("FAIL sat_ovf: ovf=%b, required 1", ovf);
    else n_pass++;
    host_read(4'd5, q, ok);
    n_chk++;
    if (!ok || q !== pack4(MAXV, MINV, 107, -107))
      $display("FAIL sat_read5: valid=%b data=%h, required 1 %h", ok, q, pack4(MAXV, MINV, 107, -107));
    else n_pass++;
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    #1;
    n_chk++;
    if (ovf !== 1'b0 || busy !== 1'b1) $display("FAIL sat_ovf_clear: ovf=%b busy=%b, required 0 1", ovf, busy);
    else n_pass++;
    wait_idle("sat_clear_done");
    model_clear();
  endtask

  task automatic test_arbitration();
    logic [LANES*OW-1:0] d, q;
    bit ok;
    @(negedge clk);
    d = pack4(11, -22, 33, -44);
    wr_valid = 1'b1; wr_addr = 4'd9; wr_data = d; acc = 1'b0;
    rd_req = 1'b1; rd_addr = 4'd9;
    #1;
    n_chk++;
    if (wr_ready !== 1'b1 || rd_gnt !== 1'b0 || mem_wen !== 1'b1 || mem_addr !== 4'd9)
      $display("FAIL arb_write_first: rdy=%b gnt=%b wen=%b addr=%0d, required 1 0 1 9", wr_ready, rd_gnt, mem_wen, mem_addr);
    else n_pass++;
    model_write(9, d, 1'b0);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    n_chk++;
    if (rd_gnt !== 1'b1) $display("FAIL arb_read_next: rd_gnt=%b, required 1", rd_gnt);
    else n_pass++;
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    n_chk++;
    if (rd_valid !== 1'b1 || rd_data !== exp_row(9))
      $display("FAIL arb_read_data: valid=%b data=%h, required 1 %h", rd_valid, rd_data, exp_row(9));
    else n_pass++;
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 4'd9; wr_data = pack4(1, 2, 3, 4); acc = 1'b1;
    #1;
    model_write(9, pack4(1, 2, 3, 4), 1'b1);
    @(negedge clk);
    wr_valid = 1'b0; acc = 1'b0; clr_req = 1'b1;
    #1;
    n_chk++;
    if (busy !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 4'd9 || mem_wdata !== exp_row(9))
      $display("FAIL arb_rmw_wb: busy=%b wen=%b addr=%0d wdata=%h, required 1 1 9 %h", busy, mem_wen, mem_addr, mem_wdata, exp_row(9));
    else n_pass++;
    @(negedge clk);
    clr_req = 1'b0;
    #1;
    n_chk++;
    if (mem_cen !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== 4'd0 || mem_wdata !== '0 || busy !== 1'b1)
      $display("FAIL arb_clear_after_rmw: cen=%b wen=%b addr=%0d busy=%b, required 1 1 0 1", mem_cen, mem_wen, mem_addr, busy);
    else n_pass++;
    wait_idle("arb_clear_done");
    model_clear();
    host_read(4'd9, q, ok);
    n_chk++;
    if (!ok || q !== '0) $display("FAIL arb_read_cleared: valid=%b data=%h, required 1 0", ok, q);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [LANES*OW-1:0] d, q;
    logic [AW-1:0] a;
    bit ok, accm;
    int l [LANES];
    @(negedge clk);
    for (int k = 0; k < 80; k++) begin
      a = AW'($urandom_range(0, DEPTH-1));
      accm = 1'($urandom_range(0, 1));
      for (int i = 0; i < LANES; i++)
        l[i] = ($urandom_range(0, 1) == 1) ? (int'($urandom) >>> 12) : (int'($urandom_range(0, 2000)) - 1000);
      d = pack4(l[0], l[1], l[2], l[3]);
      do_write(a, d, accm);
      if ($urandom_range(0, 3) == 0) begin
        a = AW'($urandom_range(0, DEPTH-1));
        host_read(a, q, ok);
        n_chk++;
        if (!ok || q !== exp_row(int'(a)))
          $display("FAIL rand_read op%0d row%0d: valid=%b data=%h, required 1 %h", k, a, ok, q, exp_row(int'(a)));
        else n_pass++;
        @(negedge clk);
      end
    end
    @(negedge clk); #1;
    n_chk++;
    if (ovf !== exp_ovf) $display("FAIL rand_ovf: ovf=%b, required %b", ovf, exp_ovf);
    else n_pass++;
    for (int r = 0; r < DEPTH; r++) begin
      host_read(AW'(r), q, ok);
      n_chk++;
      if (!ok || q !== exp_row(r))
        $display("FAIL rand_final_row%0d: valid=%b data=%h, required 1 %h", r, ok, q, exp_row(r));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_clear();
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_chk++;
    if (mem_addr !== 4'd5 || busy !== 1'b1)
      $display("FAIL rstclr_cycle5: addr=%0d busy=%b, required 5 1", mem_addr, busy);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk); #1;
    n_chk++;
    if ({wr_ready, rd_gnt, rd_valid, busy, ovf, mem_cen, mem_wen} !== 7'b0 || rd_data !== '0 || mem_addr !== '0)
      $display("FAIL rstclr_outputs: rdy/gnt/vld/busy/ovf/cen/wen=%b addr=%0d, required all 0",
               {wr_ready, rd_gnt, rd_valid, busy, ovf, mem_cen, mem_wen}, mem_addr);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (wr_ready !== 1'b1 || mem_cen !== 1'b0 || busy !== 1'b0)
      $display("FAIL rstclr_release: rdy=%b cen=%b busy=%b, required 1 0 0", wr_ready, mem_cen, busy);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_chk++;
      if (mem_cen !== 1'b0) $display("FAIL rstclr_quiet%0d: mem_cen=%b, required 0", i, mem_cen);
      else n_pass++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_overwrite();
    test_accumulate();
    test_saturation();
    test_arbitration();
    test_random();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
